// File: rtl/axis_pkg.sv
// Shared helpers and width-check constants for the AXI4-Stream width adapter family.
package axis_pkg;

   localparam int unsigned MIN_SEG_COUNT = 2;

   function automatic int unsigned seg_idx_width(int unsigned seg_count);
      return (seg_count > 1) ? $clog2(seg_count) : 1;
   endfunction

   function automatic int unsigned byte_lanes(bit keep_en, int unsigned keep_w);
      return keep_en ? keep_w : 1;
   endfunction

   function automatic bit byte_size_match(int unsigned a_width, int unsigned a_lanes,
                                          int unsigned b_width, int unsigned b_lanes);
      return ((a_width % a_lanes) == 0) && ((b_width % b_lanes) == 0) &&
             ((a_width / a_lanes) == (b_width / b_lanes));
   endfunction

endpackage

// File: rtl/axis_seg_scan.sv
// Combinational scan of per-segment keep: finds the first, next-after-idx and last
// non-empty segment.
module axis_seg_scan #(
   parameter int unsigned SEG_COUNT = 4,
   parameter int unsigned LANES     = 2,
   parameter int unsigned IDX_W     = 2
) (
   input  logic [SEG_COUNT*LANES-1:0] keep,
   input  logic [IDX_W-1:0]           idx,
   output logic [IDX_W-1:0]           first_nz,
   output logic [IDX_W-1:0]           next_nz,
   output logic [IDX_W-1:0]           last_nz,
   output logic                       any_nz
);

   logic [SEG_COUNT-1:0] seg_nz;

   always_comb begin
      seg_nz   = '0;
      first_nz = '0;
      next_nz  = idx;
      last_nz  = '0;
      any_nz   = 1'b0;
      for (int i = 0; i < int'(SEG_COUNT); i++) begin
         seg_nz[i] = |keep[i*LANES +: LANES];
      end
      // Descending walk leaves the lowest qualifying index in place.
      for (int i = int'(SEG_COUNT) - 1; i >= 0; i--) begin
         if (seg_nz[i]) begin
            first_nz = IDX_W'(i);
            if (i > int'(idx)) begin
               next_nz = IDX_W'(i);
            end
         end
      end
      for (int i = 0; i < int'(SEG_COUNT); i++) begin
         if (seg_nz[i]) begin
            last_nz = IDX_W'(i);
            any_nz  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_downsize_serializer.sv
// Wide-to-narrow AXI4-Stream serializer: one held wide beat is emitted as narrow segments,
// skipping segments whose keep is all zero.
module axis_downsize_serializer
   import axis_pkg::*;
#(
   parameter int unsigned S_DATA_WIDTH  = 64,
   parameter bit          S_KEEP_ENABLE = (S_DATA_WIDTH > 8),
   parameter int unsigned S_KEEP_WIDTH  = ((S_DATA_WIDTH + 7) / 8),
   parameter int unsigned M_DATA_WIDTH  = 16,
   parameter bit          M_KEEP_ENABLE = (M_DATA_WIDTH > 8),
   parameter int unsigned M_KEEP_WIDTH  = ((M_DATA_WIDTH + 7) / 8),
   parameter bit          ID_ENABLE     = 1'b0,
   parameter int unsigned ID_WIDTH      = 8,
   parameter bit          DEST_ENABLE   = 1'b0,
   parameter int unsigned DEST_WIDTH    = 8,
   parameter bit          USER_ENABLE   = 1'b1,
   parameter int unsigned USER_WIDTH    = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   input  logic [ID_WIDTH-1:0]     s_axis_tid,
   input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
   input  logic [USER_WIDTH-1:0]   s_axis_tuser,
   output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
   output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic [ID_WIDTH-1:0]     m_axis_tid,
   output logic [DEST_WIDTH-1:0]   m_axis_tdest,
   output logic [USER_WIDTH-1:0]   m_axis_tuser,
   output logic                    status_busy,
   output logic [seg_idx_width(S_DATA_WIDTH / M_DATA_WIDTH)-1:0] status_seg_index,
   output logic                    status_empty_drop
);

   localparam int unsigned S_BYTE_LANES = byte_lanes(S_KEEP_ENABLE, S_KEEP_WIDTH);
   localparam int unsigned M_BYTE_LANES = byte_lanes(M_KEEP_ENABLE, M_KEEP_WIDTH);
   localparam int unsigned SEG_COUNT    = S_BYTE_LANES / M_BYTE_LANES;
   localparam int unsigned IDX_W        = seg_idx_width(S_DATA_WIDTH / M_DATA_WIDTH);

   if (!byte_size_match(S_DATA_WIDTH, S_BYTE_LANES, M_DATA_WIDTH, M_BYTE_LANES)) begin : g_bad_byte
      $error("axis_downsize_serializer: input and output byte sizes differ");
   end
   if ((S_BYTE_LANES % M_BYTE_LANES) != 0) begin : g_bad_ratio
      $error("axis_downsize_serializer: input lanes not a multiple of output lanes");
   end
   if (SEG_COUNT < MIN_SEG_COUNT) begin : g_bad_count
      $error("axis_downsize_serializer: fewer than two segments per beat");
   end

   logic [SEG_COUNT-1:0][M_DATA_WIDTH-1:0] data_q;
   logic [SEG_COUNT-1:0][M_BYTE_LANES-1:0] keep_q;
   logic                                   last_q;
   logic                                   buf_valid_q;
   logic [ID_WIDTH-1:0]                    id_q;
   logic [DEST_WIDTH-1:0]                  dest_q;
   logic [USER_WIDTH-1:0]                  user_q;
   logic [IDX_W-1:0]                       seg_ptr_q;
   logic                                   empty_drop_q;

   logic [S_BYTE_LANES-1:0] keep_in;
   logic [IDX_W-1:0]        in_first, in_next, in_last;
   logic                    in_any;
   logic [IDX_W-1:0]        buf_first, buf_next, buf_last;
   logic                    buf_any;
   logic                    s_hs, m_hs, at_last_seg;

   assign keep_in = S_KEEP_ENABLE ? s_axis_tkeep[S_BYTE_LANES-1:0] : '1;

   axis_seg_scan #(
      .SEG_COUNT (SEG_COUNT),
      .LANES     (M_BYTE_LANES),
      .IDX_W     (IDX_W)
   ) u_in_scan (
      .keep     (keep_in),
      .idx      ('0),
      .first_nz (in_first),
      .next_nz  (in_next),
      .last_nz  (in_last),
      .any_nz   (in_any)
   );

   axis_seg_scan #(
      .SEG_COUNT (SEG_COUNT),
      .LANES     (M_BYTE_LANES),
      .IDX_W     (IDX_W)
   ) u_buf_scan (
      .keep     (keep_q),
      .idx      (seg_ptr_q),
      .first_nz (buf_first),
      .next_nz  (buf_next),
      .last_nz  (buf_last),
      .any_nz   (buf_any)
   );

   logic unused_scan;
   assign unused_scan = ^{in_next, in_last, buf_first, buf_any, s_axis_tkeep,
                          s_axis_tid, s_axis_tdest, s_axis_tuser};

   assign at_last_seg   = (seg_ptr_q == buf_last);
   assign s_axis_tready = !buf_valid_q || (m_axis_tready && at_last_seg);
   assign s_hs          = s_axis_tvalid && s_axis_tready;
   assign m_hs          = buf_valid_q && m_axis_tready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q       <= '0;
         keep_q       <= '0;
         last_q       <= 1'b0;
         buf_valid_q  <= 1'b0;
         id_q         <= '0;
         dest_q       <= '0;
         user_q       <= '0;
         seg_ptr_q    <= '0;
         empty_drop_q <= 1'b0;
      end else begin
         empty_drop_q <= s_hs && !in_any && !s_axis_tlast;
         // An empty beat is still stored when it carries tlast, so the frame boundary survives.
         if (s_hs && (in_any || s_axis_tlast)) begin
            data_q      <= s_axis_tdata;
            keep_q      <= keep_in;
            last_q      <= s_axis_tlast;
            id_q        <= ID_ENABLE ? s_axis_tid : '0;
            dest_q      <= DEST_ENABLE ? s_axis_tdest : '0;
            user_q      <= USER_ENABLE ? s_axis_tuser : '0;
            seg_ptr_q   <= in_first;
            buf_valid_q <= 1'b1;
         end else if (m_hs) begin
            if (at_last_seg) begin
               buf_valid_q <= 1'b0;
               seg_ptr_q   <= '0;
            end else begin
               seg_ptr_q <= buf_next;
            end
         end
      end
   end

   assign m_axis_tvalid     = buf_valid_q;
   assign m_axis_tdata      = data_q[seg_ptr_q];
   assign m_axis_tkeep      = M_KEEP_ENABLE ? keep_q[seg_ptr_q] : '1;
   assign m_axis_tlast      = buf_valid_q && last_q && at_last_seg;
   assign m_axis_tid        = id_q;
   assign m_axis_tdest      = dest_q;
   assign m_axis_tuser      = user_q;
   assign status_busy       = buf_valid_q;
   assign status_seg_index  = seg_ptr_q;
   assign status_empty_drop = empty_drop_q;

endmodule

// File: tb/tb_axis_downsize_serializer.sv
// Directed bench for axis_downsize_serializer: single-beat vector table plus
// backpressure, back-to-back and mid-beat reset sequences.
module tb_axis_downsize_serializer;

   localparam logic [63:0] BASE_DATA = 64'h8877665544332211;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] s_data = '0;
   logic [7:0]  s_keep = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        s_last = 1'b0;
   logic [7:0]  s_id = '0;
   logic [7:0]  s_dest = '0;
   logic        s_user = 1'b0;
   logic [15:0] m_data;
   logic [1:0]  m_keep;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic        m_last;
   logic [7:0]  m_id;
   logic [7:0]  m_dest;
   logic        m_user;
   logic        busy;
   logic [1:0]  seg_index;
   logic        empty_drop;

   axis_downsize_serializer #(
      .ID_ENABLE (1'b1)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .s_axis_tdata      (s_data),
      .s_axis_tkeep      (s_keep),
      .s_axis_tvalid     (s_valid),
      .s_axis_tready     (s_ready),
      .s_axis_tlast      (s_last),
      .s_axis_tid        (s_id),
      .s_axis_tdest      (s_dest),
      .s_axis_tuser      (s_user),
      .m_axis_tdata      (m_data),
      .m_axis_tkeep      (m_keep),
      .m_axis_tvalid     (m_valid),
      .m_axis_tready     (m_ready),
      .m_axis_tlast      (m_last),
      .m_axis_tid        (m_id),
      .m_axis_tdest      (m_dest),
      .m_axis_tuser      (m_user),
      .status_busy       (busy),
      .status_seg_index  (seg_index),
      .status_empty_drop (empty_drop)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: logs every handshake seen at the negedge before the accepting posedge.
   logic [15:0] q_data [256];
   logic [1:0]  q_keep [256];
   logic        q_last [256];
   logic [7:0]  q_id   [256];
   logic [7:0]  q_dest [256];
   logic        q_user [256];
   logic        q_srdy [256];
   int          q_cyc  [256];
   int          n_out = 0;
   int          drop_cnt = 0;
   int          stab_err = 0;
   logic        stall_prev = 1'b0;
   logic [15:0] prev_d;
   logic [1:0]  prev_k;
   logic        prev_l;

   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready && n_out < 256) begin
         q_data[n_out] = m_data;
         q_keep[n_out] = m_keep;
         q_last[n_out] = m_last;
         q_id[n_out]   = m_id;
         q_dest[n_out] = m_dest;
         q_user[n_out] = m_user;
         q_srdy[n_out] = s_ready;
         q_cyc[n_out]  = cyc;
         n_out = n_out + 1;
      end
      if (empty_drop) drop_cnt = drop_cnt + 1;
      if (stall_prev && rst_n) begin
         if (!(m_valid && m_data == prev_d && m_keep == prev_k && m_last == prev_l))
            stab_err = stab_err + 1;
      end
      stall_prev = rst_n && m_valid && !m_ready;
      prev_d = m_data;
      prev_k = m_keep;
      prev_l = m_last;
   end

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Presents one beat and returns #1 after the accepting posedge with tvalid still high.
   task automatic send(input logic [7:0] keep, input logic [63:0] data, input logic last,
                       input logic [7:0] id, input logic user);
      bit done = 1'b0;
      s_valid = 1'b1;
      s_keep  = keep;
      s_data  = data;
      s_last  = last;
      s_id    = id;
      s_user  = user;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if (s_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      check("send_accept", {63'd0, done}, 64'd1);
   endtask

   typedef struct packed {
      logic [7:0]       keep;
      logic             last;
      logic [2:0]       n;
      logic [3:0][15:0] d;
      logic [3:0][1:0]  k;
      logic             drop;
   } vec_t;

   vec_t        vecs [7];
   logic [63:0] bdata [16];
   int          base;
   int          drops0;
   int          gaps;
   int          side_bad;
   logic [15:0] exp_seg;

   initial begin
      vecs[0] = '{keep: 8'hFF, last: 1'b1, n: 3'd4, d: {16'h8877, 16'h6655, 16'h4433, 16'h2211},
                  k: {2'h3, 2'h3, 2'h3, 2'h3}, drop: 1'b0};
      vecs[1] = '{keep: 8'h33, last: 1'b1, n: 3'd2, d: {16'h0, 16'h0, 16'h6655, 16'h2211},
                  k: {2'h0, 2'h0, 2'h3, 2'h3}, drop: 1'b0};
      vecs[2] = '{keep: 8'h0C, last: 1'b0, n: 3'd1, d: {16'h0, 16'h0, 16'h0, 16'h4433},
                  k: {2'h0, 2'h0, 2'h0, 2'h3}, drop: 1'b0};
      vecs[3] = '{keep: 8'h81, last: 1'b1, n: 3'd2, d: {16'h0, 16'h0, 16'h8877, 16'h2211},
                  k: {2'h0, 2'h0, 2'h2, 2'h1}, drop: 1'b0};
      vecs[4] = '{keep: 8'h00, last: 1'b1, n: 3'd1, d: {16'h0, 16'h0, 16'h0, 16'h2211},
                  k: {2'h0, 2'h0, 2'h0, 2'h0}, drop: 1'b0};
      vecs[5] = '{keep: 8'h00, last: 1'b0, n: 3'd0, d: '0, k: '0, drop: 1'b1};
      vecs[6] = '{keep: 8'hC0, last: 1'b1, n: 3'd1, d: {16'h0, 16'h0, 16'h0, 16'h8877},
                  k: {2'h0, 2'h0, 2'h0, 2'h3}, drop: 1'b0};

      // Reset state.
      #12;
      check("rst_tvalid", {63'd0, m_valid}, 64'd0);
      check("rst_tdata", {48'd0, m_data}, 64'd0);
      check("rst_tkeep", {62'd0, m_keep}, 64'd0);
      check("rst_tlast", {63'd0, m_last}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_seg_index", {62'd0, seg_index}, 64'd0);
      check("rst_empty_drop", {63'd0, empty_drop}, 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("idle_tready", {63'd0, s_ready}, 64'd1);
      @(posedge clk);
      #1;

      // Single-beat vector table, output always ready.
      for (int v = 0; v < 7; v++) begin
         base   = n_out;
         drops0 = drop_cnt;
         send(vecs[v].keep, BASE_DATA, vecs[v].last, 8'h00, 1'b0);
         s_valid = 1'b0;
         repeat (8) @(posedge clk);
         #1;
         check($sformatf("v%0d_count", v), 64'(n_out - base), 64'(vecs[v].n));
         check($sformatf("v%0d_drop", v), 64'(drop_cnt - drops0), {63'd0, vecs[v].drop});
         for (int i = 0; i < int'(vecs[v].n) && (base + i) < 256; i++) begin
            check($sformatf("v%0d_s%0d_data", v, i), {48'd0, q_data[base+i]}, {48'd0, vecs[v].d[i]});
            check($sformatf("v%0d_s%0d_keep", v, i), {62'd0, q_keep[base+i]}, {62'd0, vecs[v].k[i]});
            check($sformatf("v%0d_s%0d_last", v, i), {63'd0, q_last[base+i]},
                  {63'd0, vecs[v].last && (i == int'(vecs[v].n) - 1)});
            check($sformatf("v%0d_s%0d_srdy", v, i), {63'd0, q_srdy[base+i]},
                  {63'd0, (i == int'(vecs[v].n) - 1)});
         end
      end

      // Backpressure: ready pattern 1,0,0,1 repeating.
      base = n_out;
      send(8'hFF, BASE_DATA, 1'b1, 8'h00, 1'b0);
      s_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         m_ready = (k % 4 == 0) || (k % 4 == 3);
         @(posedge clk);
         #1;
      end
      m_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("bp_count", 64'(n_out - base), 64'd4);
      for (int i = 0; i < 4 && (base + i) < 256; i++) begin
         check($sformatf("bp_s%0d_data", i), {48'd0, q_data[base+i]}, {48'd0, BASE_DATA[i*16 +: 16]});
         check($sformatf("bp_s%0d_srdy", i), {63'd0, q_srdy[base+i]}, {63'd0, (i == 3)});
      end

      // Back-to-back full beats with sideband.
      for (int b = 0; b < 16; b++) bdata[b] = {$urandom, $urandom};
      base = n_out;
      for (int b = 0; b < 16; b++) send(8'hFF, bdata[b], (b % 4 == 3), 8'd5, 1'b1);
      s_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("b2b_count", 64'(n_out - base), 64'd64);
      gaps = 0;
      side_bad = 0;
      for (int i = 0; i < 64 && (base + i) < 256; i++) begin
         exp_seg = bdata[i/4][(i%4)*16 +: 16];
         check($sformatf("b2b_s%0d_data", i), {48'd0, q_data[base+i]}, {48'd0, exp_seg});
         check($sformatf("b2b_s%0d_last", i), {63'd0, q_last[base+i]},
               {63'd0, ((i/4) % 4 == 3) && (i % 4 == 3)});
         if (q_id[base+i] != 8'd5 || q_user[base+i] != 1'b1 || q_dest[base+i] != 8'd0)
            side_bad = side_bad + 1;
         if (i > 0 && q_cyc[base+i] != q_cyc[base+i-1] + 1) gaps = gaps + 1;
      end
      check("b2b_sideband", 64'(side_bad), 64'd0);
      check("b2b_gaps", 64'(gaps), 64'd0);

      // Reset while the third segment is presented.
      m_ready = 1'b0;
      send(8'hFF, BASE_DATA, 1'b1, 8'h00, 1'b0);
      s_valid = 1'b0;
      m_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 m_ready = 1'b0;
      @(negedge clk);
      check("pre_rst_seg_index", {62'd0, seg_index}, 64'd2);
      check("pre_rst_busy", {63'd0, busy}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_tvalid", {63'd0, m_valid}, 64'd0);
      check("mid_rst_tdata", {48'd0, m_data}, 64'd0);
      check("mid_rst_tkeep", {62'd0, m_keep}, 64'd0);
      check("mid_rst_tlast", {63'd0, m_last}, 64'd0);
      check("mid_rst_busy", {63'd0, busy}, 64'd0);
      check("mid_rst_seg_index", {62'd0, seg_index}, 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      m_ready = 1'b1;
      base = n_out;
      repeat (6) @(posedge clk);
      #1;
      check("post_rst_residual", 64'(n_out - base), 64'd0);
      send(8'hFF, BASE_DATA, 1'b1, 8'h00, 1'b0);
      s_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("post_rst_count", 64'(n_out - base), 64'd4);
      if (base < 256) check("post_rst_first", {48'd0, q_data[base]}, 64'h2211);
      if (base + 3 < 256) check("post_rst_last", {63'd0, q_last[base+3]}, 64'd1);

      check("stall_stability", 64'(stab_err), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
